nonce_sweeper: RTL and testbench

Upstream scheduler for the SHA-256d miner datapath. Latches a 640-bit block header from the host, then drives a stable header and nonce into the miner for exactly one full three-pass attempt per nonce, stepping through an inclusive nonce range. It captures the first nonce/hash pair the miner flags as meeting difficulty and holds it for the host until acknowledged. It also generates the miner's one-cycle realignment reset, so the miner's pass counter is phase-locked to this block's attempt counter.

---
 rtl/nonce_sweeper.sv | 119 +++++++++++
 tb/tb_nonce_sweeper.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/nonce_sweeper.sv
// Schedules header/nonce attempts into the SHA-256d miner over an inclusive, wrapping nonce range.
// Latency: header accept -> SYNC next cycle -> RUN cycle after; one nonce per CYCLES_PER_NONCE clocks.
// Backpressure: header_ready only in IDLE; a found/exhausted result stalls the sweep until result_ack.
module nonce_sweeper #(
    parameter int CYCLES_PER_NONCE = 198
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [639:0] header_in,
    input  logic         header_valid,
    output logic         header_ready,
    input  logic [31:0]  start_nonce,
    input  logic [31:0]  end_nonce,
    input  logic         abort,
    input  logic         result_ack,
    output logic [639:0] block_header,
    output logic [31:0]  nonce,
    output logic         miner_reset,
    input  logic         hash_success,
    input  logic [255:0] hash_in,
    output logic         busy,
    output logic         found,
    output logic [31:0]  found_nonce,
    output logic [255:0] found_hash,
    output logic         exhausted
);

    localparam int CW = (CYCLES_PER_NONCE > 2) ? $clog2(CYCLES_PER_NONCE) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(CYCLES_PER_NONCE - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SYNC  = 3'd1,
        RUN   = 3'd2,
        FOUND = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [31:0]   end_q;
    logic          exhausted_q;

    // Status outputs are pure decodes of the state register, so they never glitch.
    assign header_ready = (state == IDLE);
    assign busy         = (state == SYNC) || (state == RUN);
    assign miner_reset  = (state == SYNC);
    assign found        = (state == FOUND);
    assign exhausted    = exhausted_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            end_q        <= '0;
            nonce        <= '0;
            block_header <= '0;
            found_nonce  <= '0;
            found_hash   <= '0;
            exhausted_q  <= 1'b0;
        end else if (abort && state != IDLE) begin
            state       <= IDLE;
            exhausted_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (header_valid) begin
                        block_header <= header_in;
                        nonce        <= start_nonce;
                        end_q        <= end_nonce;
                        state        <= SYNC;
                    end
                end
                SYNC: begin
                    cnt   <= '0;
                    state <= RUN;
                end
                RUN: begin
                    // A hit wins over the end-of-attempt decision on the same cycle.
                    if (hash_success) begin
                        found_nonce <= nonce;
                        found_hash  <= hash_in;
                        state       <= FOUND;
                    end else if (cnt == LAST_CNT) begin
                        if (nonce == end_q) begin
                            exhausted_q <= 1'b1;
                            state       <= DONE;
                        end else begin
                            nonce <= nonce + 32'd1;
                            cnt   <= '0;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                FOUND: begin
                    // Miner free-ran while we waited, so resume through SYNC to realign it.
                    if (result_ack) begin
                        if (nonce == end_q) begin
                            exhausted_q <= 1'b0;
                            state       <= DONE;
                        end else begin
                            nonce <= nonce + 32'd1;
                            state <= SYNC;
                        end
                    end
                end
                DONE: begin
                    if (result_ack) begin
                        exhausted_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nonce_sweeper.sv
// Directed bench for nonce_sweeper: range sweeps, wrap, hits, abort priority, async reset.
module tb_nonce_sweeper;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [639:0] header_in = '0;
    logic         header_valid = 1'b0;
    logic         header_ready;
    logic [31:0]  start_nonce = '0;
    logic [31:0]  end_nonce = '0;
    logic         abort = 1'b0;
    logic         result_ack = 1'b0;
    logic [639:0] block_header;
    logic [31:0]  nonce;
    logic         miner_reset;
    logic         hash_success = 1'b0;
    logic [255:0] hash_in = '0;
    logic         busy;
    logic         found;
    logic [31:0]  found_nonce;
    logic [255:0] found_hash;
    logic         exhausted;

    int tests = 0;
    int fails = 0;

    nonce_sweeper #(.CYCLES_PER_NONCE(198)) dut (
        .clk(clk), .rst_n(rst_n),
        .header_in(header_in), .header_valid(header_valid), .header_ready(header_ready),
        .start_nonce(start_nonce), .end_nonce(end_nonce),
        .abort(abort), .result_ack(result_ack),
        .block_header(block_header), .nonce(nonce), .miner_reset(miner_reset),
        .hash_success(hash_success), .hash_in(hash_in),
        .busy(busy), .found(found), .found_nonce(found_nonce), .found_hash(found_hash),
        .exhausted(exhausted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [639:0] obs, input logic [639:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks the nonce stays put and no realign pulse appears for n cycles, then leaves after n edges.
    task automatic hold(input int n, input logic [31:0] v, input string tag);
        int bad = 0;
        for (int i = 0; i < n; i++) begin
            if (nonce !== v || miner_reset !== 1'b0 || busy !== 1'b1) bad++;
            tick();
        end
        chk(tag, 640'(bad), 640'd0);
    endtask

    task automatic start_job(input logic [639:0] h, input logic [31:0] s, input logic [31:0] e);
        header_in    = h;
        start_nonce  = s;
        end_nonce    = e;
        header_valid = 1'b1;
        tick();
        header_valid = 1'b0;
    endtask

    task automatic ack();
        result_ack = 1'b1;
        tick();
        result_ack = 1'b0;
    endtask

    logic [639:0] h1, h2;

    initial begin
        h1 = {8{80'h0123456789ABCDEF0011}};
        h2 = {10{64'hDEADBEEF_CAFEF00D}};

        // Reset values
        #3;
        chk("rst_ready", 640'(header_ready), 640'd1);
        chk("rst_busy", 640'(busy), 640'd0);
        chk("rst_found", 640'(found), 640'd0);
        chk("rst_exh", 640'(exhausted), 640'd0);
        chk("rst_mreset", 640'(miner_reset), 640'd0);
        chk("rst_nonce", 640'(nonce), 640'd0);
        chk("rst_hdr", block_header, 640'd0);
        chk("rst_fhash", 640'(found_hash), 640'd0);
        #12 rst_n = 1'b1;
        tick();

        // Sweep 5..7, no hits
        start_job(h1, 32'd5, 32'd7);
        chk("t1_sync_mreset", 640'(miner_reset), 640'd1);
        chk("t1_sync_nonce", 640'(nonce), 640'd5);
        chk("t1_sync_ready", 640'(header_ready), 640'd0);
        chk("t1_hdr", block_header, h1);
        tick();
        hold(198, 32'd5, "t1_hold5");
        hold(198, 32'd6, "t1_hold6");
        hold(198, 32'd7, "t1_hold7");
        chk("t1_exh", 640'(exhausted), 640'd1);
        chk("t1_busy", 640'(busy), 640'd0);
        chk("t1_found", 640'(found), 640'd0);
        ack();
        chk("t1_ready", 640'(header_ready), 640'd1);
        chk("t1_exh_clr", 640'(exhausted), 640'd0);

        // Wrapping range FFFFFFFE..00000001
        start_job(h2, 32'hFFFF_FFFE, 32'h0000_0001);
        tick();
        hold(198, 32'hFFFF_FFFE, "t2_hold_fe");
        hold(198, 32'hFFFF_FFFF, "t2_hold_ff");
        hold(198, 32'h0000_0000, "t2_hold_00");
        hold(198, 32'h0000_0001, "t2_hold_01");
        chk("t2_exh", 640'(exhausted), 640'd1);
        ack();

        // Hit mid-attempt on the second nonce
        start_job(h1, 32'd10, 32'd20);
        tick();
        hold(198, 32'd10, "t3_hold10");
        repeat (50) tick();
        hash_success = 1'b1;
        hash_in      = 256'hABC;
        tick();
        hash_success = 1'b0;
        chk("t3_found", 640'(found), 640'd1);
        chk("t3_fnonce", 640'(found_nonce), 640'd11);
        chk("t3_fhash", 640'(found_hash), 640'hABC);
        chk("t3_busy", 640'(busy), 640'd0);
        hash_success = 1'b1;
        hash_in      = 256'h1234;
        tick();
        hash_success = 1'b0;
        chk("t3_ignore_hit", 640'(found_hash), 640'hABC);
        ack();
        chk("t3_resync", 640'(miner_reset), 640'd1);
        chk("t3_nonce12", 640'(nonce), 640'd12);
        chk("t3_found_clr", 640'(found), 640'd0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t3_abort_idle", 640'(header_ready), 640'd1);

        // Hit on the final count of the last attempt
        start_job(h2, 32'd30, 32'd30);
        tick();
        repeat (197) tick();
        chk("t4_nonce", 640'(nonce), 640'd30);
        hash_success = 1'b1;
        hash_in      = 256'h55;
        tick();
        hash_success = 1'b0;
        chk("t4_found", 640'(found), 640'd1);
        chk("t4_exh0", 640'(exhausted), 640'd0);
        chk("t4_fnonce", 640'(found_nonce), 640'd30);
        ack();
        chk("t4_done_exh", 640'(exhausted), 640'd0);
        chk("t4_done_found", 640'(found), 640'd0);
        chk("t4_done_ready", 640'(header_ready), 640'd0);
        ack();
        chk("t4_idle", 640'(header_ready), 640'd1);

        // Single-nonce range, no hit
        start_job(h1, 32'd40, 32'd40);
        tick();
        hold(198, 32'd40, "t4b_hold40");
        chk("t4b_exh", 640'(exhausted), 640'd1);
        ack();

        // Abort beats a same-cycle hit
        start_job(h1, 32'd100, 32'd200);
        tick();
        repeat (20) tick();
        abort        = 1'b1;
        hash_success = 1'b1;
        tick();
        abort        = 1'b0;
        hash_success = 1'b0;
        chk("t5_ready", 640'(header_ready), 640'd1);
        chk("t5_found", 640'(found), 640'd0);
        chk("t5_busy", 640'(busy), 640'd0);
        chk("t5_exh", 640'(exhausted), 640'd0);

        // Async reset mid-RUN at counter 100
        start_job(h2, 32'd50, 32'd60);
        tick();
        repeat (100) tick();
        chk("t6_pre_nonce", 640'(nonce), 640'd50);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_nonce", 640'(nonce), 640'd0);
        chk("t6_busy", 640'(busy), 640'd0);
        chk("t6_ready", 640'(header_ready), 640'd1);
        chk("t6_fnonce", 640'(found_nonce), 640'd0);
        chk("t6_hdr", block_header, 640'd0);
        #1 rst_n = 1'b1;
        tick();
        start_job(h1, 32'd77, 32'd78);
        chk("t6_sync", 640'(miner_reset), 640'd1);
        chk("t6_sync_nonce", 640'(nonce), 640'd77);
        tick();
        chk("t6_run", 640'(miner_reset), 640'd0);
        chk("t6_run_busy", 640'(busy), 640'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
